jogo_sequencia_param: RTL and testbench
=======================================

JOGO_SEQUENCIA_PARAM -- requirements
Module: jogo_sequencia_param

Interface
REQ-001 Parameter DATA_WIDTH, default 4: width of keys, ROM word and registered play.
REQ-002 Parameter DEPTH, default 16: sequence length; ADDR_WIDTH = clog2(DEPTH), minimum 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 5000: inactivity limit in clock cycles.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 Port list:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- iniciar  in  1  start request.
- chaves  in  DATA_WIDTH  player keys.
- pronto  out  1  round finished.
- acertou  out  1  full sequence matched.
- errou  out  1  mismatch or timeout.
- timeout  out  1  round ended by inactivity.
- db_igual  out  1  ROM word equals registered play.
- db_jogada_pulso  out  1  detected play pulse.
- db_contagem  out  ADDR_WIDTH  current address.
- db_memoria  out  DATA_WIDTH  ROM output.
- db_jogada  out  DATA_WIDTH  registered play.
- db_estado  out  4  state code.

Function
REQ-006 Play detection SHALL be an edge detector: jogada_pulso = (|chaves) & ~prev, where prev is |chaves registered every cycle; a held key yields one pulse.
REQ-007 ROM SHALL be synchronous with 1-cycle read latency; default contents word[i] = 1 << (i mod DATA_WIDTH).
REQ-008 States and db_estado codes SHALL be: INICIAL 0, PREPARACAO 1, ESPERA 2, REGISTRA 4, COMPARA 5, PROXIMO 6, FIM_ACERTO A, FIM_ERRO E, FIM_TIMEOUT D; any illegal encoding SHALL go to INICIAL and show F.
REQ-009 Transitions SHALL be:
- INICIAL -> PREPARACAO on iniciar.
- PREPARACAO -> ESPERA.
- ESPERA -> REGISTRA on jogada_pulso.
- REGISTRA -> COMPARA.
- COMPARA -> FIM_ERRO if not equal; else FIM_ACERTO if address = DEPTH-1; else PROXIMO.
- PROXIMO -> ESPERA.
- FIM_* -> PREPARACAO on iniciar; otherwise hold.
REQ-010 PREPARACAO SHALL clear the address counter and the play register; REGISTRA SHALL load chaves; PROXIMO SHALL increment the address by exactly 1, with no wrap inside a round.
REQ-011 Outputs SHALL be Moore: pronto in any FIM_*; acertou only in FIM_ACERTO; errou in FIM_ERRO or FIM_TIMEOUT; timeout only in FIM_TIMEOUT.
REQ-012 iniciar SHALL be ignored outside INICIAL and FIM_*; key changes SHALL be ignored outside ESPERA.
REQ-013 db_igual SHALL be a combinational equality of db_memoria and db_jogada.

Reset
REQ-014 On reset, at the next rising edge: state INICIAL, address 0, play register 0, edge-detector prev 0, timeout counter 0; all status outputs 0.
REQ-015 Reset asserted in any state, including mid-round, SHALL take priority over every other input.

Configuration
REQ-016 With macro JOGO_TIMEOUT_EN defined:
- A counter SHALL count cycles spent in ESPERA and clear in every other state.
- Reaching TIMEOUT_CYCLES-1 without jogada_pulso SHALL transition ESPERA -> FIM_TIMEOUT.
- jogada_pulso in the same cycle SHALL win.
REQ-017 Without JOGO_TIMEOUT_EN: no counter is built, timeout is tied to 0, and FIM_TIMEOUT is unreachable.

Structure
REQ-018 A shared package SHALL hold the state encodings/db_estado codes and default parameter constants.
REQ-019 One sub-module, rom_sequencia (parametrised DATA_WIDTH, DEPTH, synchronous), SHALL hold the ROM; the edge detector, FSM and counters SHALL stay inline.

Verification (DATA_WIDTH=4, DEPTH=16, TIMEOUT_CYCLES=20)
REQ-020 Full correct round: plays 1,2,4,8 repeated to 16 plays -> FIM_ACERTO, pronto=1, acertou=1, errou=0, db_estado=A, db_contagem=F.
REQ-021 Error at address 2: plays 1,2,then 8 -> FIM_ERRO, errou=1, db_contagem=2, db_jogada=8, db_estado=E.
REQ-022 Key held 10 cycles in ESPERA -> exactly one play registered; address advances by 1.
REQ-023 With JOGO_TIMEOUT_EN: no key for 20 cycles in ESPERA -> FIM_TIMEOUT, errou=1, timeout=1, db_estado=D; a key edge on cycle 19 -> REGISTRA instead.
REQ-024 reset pulse in COMPARA -> INICIAL next edge, all outputs 0; iniciar from FIM_ERRO -> PREPARACAO, address 0.

Source files
------------

// File: rtl/jogo_sequencia_pkg.sv
// Shared definitions for the sequence game: FSM state encodings (which are
// also the db_estado debug codes) and default parameter values.
package jogo_sequencia_pkg;

  localparam int DATA_WIDTH_DEF     = 4;
  localparam int DEPTH_DEF          = 16;
  localparam int TIMEOUT_CYCLES_DEF = 5000;

  // Encodings double as the db_estado codes, so the debug port is the register.
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  // Shown on db_estado whenever the state register holds no legal encoding.
  localparam logic [3:0] CODIGO_ILEGAL = 4'hF;

  function automatic logic estado_valido(input estado_t e);
    case (e)
      INICIAL, PREPARACAO, ESPERA, REGISTRA, COMPARA, PROXIMO,
      FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic estado_final(input estado_t e);
    return (e == FIM_ACERTO) || (e == FIM_ERRO) || (e == FIM_TIMEOUT);
  endfunction

endpackage

// File: rtl/jogo_sequencia_param_rom_sequencia.sv
// Synchronous sequence ROM: one-cycle read latency, word[i] = 1 << (i mod DATA_WIDTH).
// Addresses at or beyond DEPTH read as zero.
module rom_sequencia #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 16,
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clock,
  input  logic [ADDR_WIDTH-1:0] endereco,
  output logic [DATA_WIDTH-1:0] dado
);

  function automatic logic [DATA_WIDTH-1:0] palavra(input int i);
    if (i < DEPTH) return DATA_WIDTH'(1) << (i % DATA_WIDTH);
    else           return '0;
  endfunction

  // Registered read port; contents are constant so no reset is needed.
  always_ff @(posedge clock) begin
    dado <= palavra(int'(endereco));
  end

endmodule

// File: rtl/jogo_sequencia_param.sv
// Sequence game: the player must reproduce the ROM sequence one key press at
// a time. Key presses are reduced to single-cycle pulses by an edge detector.
// Optional build macro JOGO_TIMEOUT_EN adds an inactivity timeout while the
// FSM waits for a play; without it FIM_TIMEOUT is unreachable and timeout = 0.
module jogo_sequencia_param
  import jogo_sequencia_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int DEPTH          = DEPTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int ADDR_WIDTH    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic [DATA_WIDTH-1:0] chaves,
  output logic                  pronto,
  output logic                  acertou,
  output logic                  errou,
  output logic                  timeout,
  output logic                  db_igual,
  output logic                  db_jogada_pulso,
  output logic [ADDR_WIDTH-1:0] db_contagem,
  output logic [DATA_WIDTH-1:0] db_memoria,
  output logic [DATA_WIDTH-1:0] db_jogada,
  output logic [3:0]            db_estado
);

  if (DATA_WIDTH < 1 || DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_invalido
    $error("jogo_sequencia_param: DATA_WIDTH, DEPTH and TIMEOUT_CYCLES must be >= 1");
  end

  localparam logic [ADDR_WIDTH-1:0] ULTIMO = ADDR_WIDTH'(DEPTH - 1);

  estado_t               estado, proximo;
  logic                  prev;
  logic                  jogada_pulso;
  logic                  expirou;
  logic [ADDR_WIDTH-1:0] endereco;
  logic [DATA_WIDTH-1:0] jogada;
  logic [DATA_WIDTH-1:0] memoria;

  assign jogada_pulso = (|chaves) & ~prev;

  rom_sequencia #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_rom (
    .clock    (clock),
    .endereco (endereco),
    .dado     (memoria)
  );

`ifdef JOGO_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] cont_timeout;

  assign expirou = (estado == ESPERA) && (cont_timeout == TW'(TIMEOUT_CYCLES - 1));

  // Counts cycles spent waiting for a play; cleared in every other state.
  always_ff @(posedge clock) begin
    if (reset)                            cont_timeout <= '0;
    else if (estado == ESPERA && !expirou) cont_timeout <= cont_timeout + TW'(1);
    else                                  cont_timeout <= '0;
  end
`else
  assign expirou = 1'b0;
`endif

  // Next-state logic; a play pulse beats an expiring timeout in the same cycle.
  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:    if (iniciar) proximo = PREPARACAO;
      PREPARACAO: proximo = ESPERA;
      ESPERA: begin
        if (jogada_pulso) proximo = REGISTRA;
        else if (expirou) proximo = FIM_TIMEOUT;
      end
      REGISTRA:   proximo = COMPARA;
      COMPARA: begin
        if (memoria != jogada)    proximo = FIM_ERRO;
        else if (endereco == ULTIMO) proximo = FIM_ACERTO;
        else                      proximo = PROXIMO;
      end
      PROXIMO:    proximo = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (iniciar) proximo = PREPARACAO;
      default:    proximo = INICIAL;
    endcase
  end

  // State register with Moore status outputs registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= INICIAL;
      pronto  <= 1'b0;
      acertou <= 1'b0;
      errou   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      estado  <= proximo;
      pronto  <= estado_final(proximo);
      acertou <= (proximo == FIM_ACERTO);
      errou   <= (proximo == FIM_ERRO) || (proximo == FIM_TIMEOUT);
      timeout <= (proximo == FIM_TIMEOUT);
    end
  end

  // Edge-detector history, address counter and play register.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev     <= 1'b0;
      endereco <= '0;
      jogada   <= '0;
    end else begin
      prev <= |chaves;
      if (estado == PREPARACAO) begin
        endereco <= '0;
        jogada   <= '0;
      end else begin
        if (estado == REGISTRA) jogada   <= chaves;
        if (estado == PROXIMO)  endereco <= endereco + ADDR_WIDTH'(1);
      end
    end
  end

  assign db_igual        = (memoria == jogada);
  assign db_jogada_pulso = jogada_pulso;
  assign db_contagem     = endereco;
  assign db_memoria      = memoria;
  assign db_jogada       = jogada;
  assign db_estado       = estado_valido(estado) ? estado : CODIGO_ILEGAL;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Self-checking bench for jogo_sequencia_param (DATA_WIDTH=4, DEPTH=16,
// TIMEOUT_CYCLES=20). Timeout checks follow the JOGO_TIMEOUT_EN build macro.
module tb_jogo_sequencia_param;

  localparam int DW = 4;
  localparam int DP = 16;
  localparam int TO = 20;

  logic          clock = 1'b0;
  logic          reset, iniciar;
  logic [DW-1:0] chaves;
  logic          pronto, acertou, errou, timeout, db_igual, db_jogada_pulso;
  logic [3:0]    db_contagem;
  logic [DW-1:0] db_memoria, db_jogada;
  logic [3:0]    db_estado;

  int n_checks = 0;
  int n_errors = 0;
  int seq [DP];

  jogo_sequencia_param #(
    .DATA_WIDTH     (DW),
    .DEPTH          (DP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .iniciar         (iniciar),
    .chaves          (chaves),
    .pronto          (pronto),
    .acertou         (acertou),
    .errou           (errou),
    .timeout         (timeout),
    .db_igual        (db_igual),
    .db_jogada_pulso (db_jogada_pulso),
    .db_contagem     (db_contagem),
    .db_memoria      (db_memoria),
    .db_jogada       (db_jogada),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic espera_estado(input logic [3:0] cod, input int limite);
    int n = 0;
    while (db_estado !== cod && n < limite) begin
      @(negedge clock);
      n++;
    end
    verifica("alcanca_estado", db_estado, cod);
  endtask

  task automatic inicia();
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    verifica("inicia_preparacao", db_estado, 4'h1);
  endtask

  // Waits for ESPERA, idles a few cycles, presses val for hold cycles, releases.
  task automatic jogar(input logic [DW-1:0] val, input int hold);
    espera_estado(4'h2, 60);
    repeat ($urandom_range(0, 5)) @(negedge clock);
    chaves = val;
    repeat (hold) @(negedge clock);
    chaves = '0;
    @(negedge clock);
  endtask

  task automatic espera_fim();
    int n = 0;
    while (pronto !== 1'b1 && n < 30) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic confere_fim(input string tag, input bit acerto,
                             input int cont, input logic [DW-1:0] jog);
    espera_fim();
    verifica({tag, "_pronto"},   pronto,  1'b1);
    verifica({tag, "_acertou"},  acertou, acerto);
    verifica({tag, "_errou"},    errou,   !acerto);
    verifica({tag, "_timeout"},  timeout, 1'b0);
    verifica({tag, "_estado"},   db_estado, acerto ? 4'hA : 4'hE);
    verifica({tag, "_contagem"}, db_contagem, cont);
    verifica({tag, "_jogada"},   db_jogada, jog);
  endtask

  task automatic pulso_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] plays [DP];
    int erro_em;

    for (int i = 0; i < DP; i++) seq[i] = 2 ** (i % DW);

    reset = 1'b1; iniciar = 1'b0; chaves = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    verifica("rst_estado",   db_estado, 4'h0);
    verifica("rst_status",   {pronto, acertou, errou, timeout}, 4'h0);
    verifica("rst_contagem", db_contagem, 0);
    verifica("rst_jogada",   db_jogada, 0);

    // Keys in INICIAL do not start anything.
    chaves = 4'h3;
    repeat (3) @(negedge clock);
    verifica("chaves_ignoradas", db_estado, 4'h0);
    chaves = '0;
    @(negedge clock);

    // Full correct round; first play held 10 cycles registers only once.
    inicia();
    @(negedge clock);
    verifica("espera_inicial", db_estado, 4'h2);
    iniciar = 1'b1;
    repeat (2) @(negedge clock);
    iniciar = 1'b0;
    verifica("iniciar_ignorado", db_estado, 4'h2);
    chaves = 4'h1;
    repeat (10) @(negedge clock);
    verifica("hold_estado",   db_estado, 4'h2);
    verifica("hold_contagem", db_contagem, 1);
    verifica("hold_jogada",   db_jogada, 1);
    verifica("hold_memoria",  db_memoria, seq[1]);
    verifica("hold_igual",    db_igual, 1'b0);
    chaves = '0;
    @(negedge clock);
    for (int i = 1; i < DP; i++) jogar(seq[i], 2);
    confere_fim("acerto", 1'b1, DP - 1, seq[DP-1]);
    verifica("acerto_igual", db_igual, 1'b1);

    // Error at address 2.
    inicia();
    jogar(4'h1, 2);
    jogar(4'h2, 3);
    jogar(4'h8, 2);
    confere_fim("erro", 1'b0, 2, 4'h8);

    // Restart from FIM_ERRO, then reset while in COMPARA.
    inicia();
    espera_estado(4'h2, 10);
    verifica("reinicio_contagem", db_contagem, 0);
    verifica("reinicio_jogada",   db_jogada, 0);
    jogar(4'h1, 2);
    espera_estado(4'h2, 10);
    chaves = 4'h2;
    repeat (2) @(negedge clock);
    verifica("compara_estado", db_estado, 4'h5);
    pulso_reset();
    chaves = '0;
    verifica("rst_compara_estado",   db_estado, 4'h0);
    verifica("rst_compara_status",   {pronto, acertou, errou, timeout}, 4'h0);
    verifica("rst_compara_contagem", db_contagem, 0);
    verifica("rst_compara_jogada",   db_jogada, 0);
    @(negedge clock);

`ifdef JOGO_TIMEOUT_EN
    inicia();
    espera_estado(4'h2, 10);
    repeat (TO - 1) @(negedge clock);
    verifica("to_ultimo_ciclo", db_estado, 4'h2);
    @(negedge clock);
    verifica("to_estado",  db_estado, 4'hD);
    verifica("to_status",  {pronto, acertou, errou, timeout}, 4'b1011);
    inicia();
    espera_estado(4'h2, 10);
    repeat (TO - 1) @(negedge clock);
    chaves = 4'h1;
    @(negedge clock);
    verifica("to_pulso_vence", db_estado, 4'h4);
    @(negedge clock);
    chaves = '0;
    @(negedge clock);
    pulso_reset();
`else
    inicia();
    espera_estado(4'h2, 10);
    repeat (2 * TO) @(negedge clock);
    verifica("sem_to_estado",  db_estado, 4'h2);
    verifica("sem_to_timeout", timeout, 1'b0);
    pulso_reset();
`endif

    // Randomized rounds against the sequence model.
    for (int r = 0; r < 12; r++) begin
      erro_em = -1;
      for (int i = 0; i < DP; i++) begin
        if ($urandom_range(0, 11) == 0) begin
          plays[i] = DW'($urandom_range(1, 15));
          if (int'(plays[i]) == seq[i]) plays[i] = plays[i] ^ 4'h3;
          if (erro_em < 0) erro_em = i;
        end else begin
          plays[i] = DW'(seq[i]);
        end
      end
      inicia();
      for (int i = 0; i < DP; i++) begin
        jogar(plays[i], $urandom_range(2, 4));
        if (i == erro_em) break;
      end
      if (erro_em < 0) confere_fim("rand_acerto", 1'b1, DP - 1, DW'(seq[DP-1]));
      else             confere_fim("rand_erro", 1'b0, erro_em, plays[erro_em]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
